// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues word-aligned fetches under a credit limit,
// buffers returned words with their PCs, and discards stale responses after a redirect.
module instr_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
);

    localparam int unsigned     PTR_W = $clog2(BUF_DEPTH);
    localparam int unsigned     CNT_W = 3;
    localparam logic [CNT_W-1:0] DEPTH = CNT_W'(BUF_DEPTH);
    localparam logic [31:0]     NOP   = 32'h0000_0013;

    logic [31:0]      fetch_pc;
    logic [CNT_W-1:0] occupancy;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] drop_cnt;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [31:0]      buf_instr [BUF_DEPTH];
    logic [31:0]      buf_pc    [BUF_DEPTH];

    logic        accept;
    logic        push;
    logic        pop;
    logic [31:0] resp_pc;

    // Credits count both buffered words and words still in flight, so a
    // request is only offered when its response is guaranteed a slot.
    always_comb begin
        imem_req_valid = rst_n && !redirect_valid && (drop_cnt == '0)
                         && ((outstanding + occupancy) < DEPTH);
        imem_req_addr  = fetch_pc;
        accept         = imem_req_valid && imem_req_ready;
        push           = imem_resp_valid && (drop_cnt == '0) && !redirect_valid;
        pop            = instr_valid && instr_ready && !redirect_valid;
        // Responses are in order, so the oldest in-flight address is recoverable.
        resp_pc        = fetch_pc - {27'b0, outstanding, 2'b00};
    end

    always_comb begin
        instr_valid = (occupancy != '0);
        instr       = NOP;
        instr_pc    = '0;
        if (instr_valid) begin
            instr    = buf_instr[head];
            instr_pc = buf_pc[head];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            occupancy   <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            head        <= '0;
            tail        <= '0;
        end else if (redirect_valid) begin
            // Everything still in flight (old drops or live requests) must be
            // discarded, less the response consumed in this very cycle.
            fetch_pc    <= {redirect_pc[31:2], 2'b00};
            drop_cnt    <= drop_cnt + outstanding - CNT_W'(imem_resp_valid);
            outstanding <= '0;
            occupancy   <= '0;
            head        <= '0;
            tail        <= '0;
        end else begin
            if (accept)
                fetch_pc <= fetch_pc + 32'd4;
            if (push)
                tail <= tail + PTR_W'(1);
            if (pop)
                head <= head + PTR_W'(1);
            occupancy   <= occupancy + CNT_W'(push) - CNT_W'(pop);
            outstanding <= outstanding + CNT_W'(accept) - CNT_W'(push);
            if (imem_resp_valid && (drop_cnt != '0))
                drop_cnt <= drop_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_instr[tail] <= imem_resp_data;
            buf_pc[tail]    <= resp_pc;
        end
    end

endmodule
